fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller_if.sv | 21 ++
 rtl/fetch_controller.sv | 108 ++++++++++
 tb/tb_fetch_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Instruction-memory read channel between the fetch controller (master) and memory (slave).
interface fetch_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  mem_req_valid;
  logic [DATA_WIDTH-1:0] mem_req_addr;
  logic                  mem_req_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_data;
  logic                  mem_resp_err;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err
  );
endinterface

// File: rtl/fetch_controller.sv
// Single-outstanding instruction fetch sequencer: request, wait (with timeout), hold for decode,
// step the PC. Any misalignment, bus error or timeout parks the block in FAULT until reset.
module fetch_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pc_current,
  input  logic                  fetch_en,
  fetch_controller_if.master    mem,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  update_pc,
  output logic                  fetch_fault,
  output logic [1:0]            fault_cause,
  output logic [DATA_WIDTH-1:0] fault_addr,
  output logic [31:0]           fetch_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_STEP, S_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
  // Counter holds the number of WAIT cycles already elapsed, so expiry is on the last allowed one.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [7:0]            to_cnt;
  logic [DATA_WIDTH-1:0] req_addr_q;
  logic                  misaligned;
  logic                  expired;

  assign misaligned = (pc_current[1:0] != 2'b00);
  assign expired    = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fetch_en) state_nxt = misaligned ? S_FAULT : S_REQ;
      S_REQ:   if (mem.mem_req_ready) state_nxt = S_WAIT;
      // A response arriving on the expiry cycle takes priority over the timeout.
      S_WAIT:  if (mem.mem_resp_valid) state_nxt = mem.mem_resp_err ? S_FAULT : S_HOLD;
               else if (expired)       state_nxt = S_FAULT;
      S_HOLD:  if (instr_ready) state_nxt = S_STEP;
      S_STEP:  state_nxt = S_IDLE;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      instr       <= '0;
      fault_cause <= 2'b00;
      fault_addr  <= '0;
      fetch_count <= '0;
      to_cnt      <= '0;
    end else begin
      if (state != S_WAIT) to_cnt <= '0;
      case (state)
        S_IDLE: if (fetch_en) begin
          if (misaligned) begin
            fault_cause <= CAUSE_MISALIGN;
            fault_addr  <= pc_current;
          end else begin
            req_addr_q  <= pc_current;
          end
        end
        S_WAIT: begin
          if (mem.mem_resp_valid) begin
            if (mem.mem_resp_err) begin
              fault_cause <= CAUSE_BUS_ERR;
              fault_addr  <= req_addr_q;
            end else begin
              instr <= mem.mem_resp_data;
            end
          end else begin
            to_cnt <= to_cnt + 8'd1;
            if (expired) begin
              fault_cause <= CAUSE_TIMEOUT;
              fault_addr  <= req_addr_q;
            end
          end
        end
        S_STEP: fetch_count <= fetch_count + 32'd1;
        default: ;
      endcase
    end
  end

  assign mem.mem_req_valid = (state == S_REQ);
  assign mem.mem_req_addr  = req_addr_q;
  assign instr_valid       = (state == S_HOLD);
  assign update_pc         = (state == S_STEP);
  assign fetch_fault       = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller (TIMEOUT_CYCLES=4): normal fetch, stalls, timeout, faults, reset.
module tb_fetch_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_current;
  logic        fetch_en;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        update_pc;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;
  int checks = 0;
  int errors = 0;

  fetch_controller_if #(.DATA_WIDTH(32)) mem_bus ();

  fetch_controller #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_current(pc_current), .fetch_en(fetch_en), .mem(mem_bus),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready), .update_pc(update_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chkb({tag, "_req_valid"},   mem_bus.mem_req_valid, 1'b0);
    chk ({tag, "_req_addr"},    mem_bus.mem_req_addr, 32'h0);
    chk ({tag, "_instr"},       instr, 32'h0);
    chkb({tag, "_instr_valid"}, instr_valid, 1'b0);
    chkb({tag, "_update_pc"},   update_pc, 1'b0);
    chkb({tag, "_fault"},       fetch_fault, 1'b0);
    chk ({tag, "_cause"},       32'(fault_cause), 32'h0);
    chk ({tag, "_fault_addr"},  fault_addr, 32'h0);
    chk ({tag, "_count"},       fetch_count, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1; fetch_en = 1'b0; pc_current = '0; instr_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b0;
    mem_bus.mem_resp_data = '0;   mem_bus.mem_resp_err = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("por");
    tick(); tick();

    // Basic fetch at 0x0 with everything ready at the earliest opportunity.
    pc_current = 32'h0; fetch_en = 1'b1; instr_ready = 1'b1;
    mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 32'h00500093;
    rst_n = 1'b1;
    tick(); chkb("f1_req_valid", mem_bus.mem_req_valid, 1'b1); chk("f1_req_addr", mem_bus.mem_req_addr, 32'h0);
            chkb("f1_req_upd", update_pc, 1'b0);
    tick(); chkb("f1_wait_valid", mem_bus.mem_req_valid, 1'b0); chkb("f1_wait_ivalid", instr_valid, 1'b0);
    tick(); chkb("f1_hold_ivalid", instr_valid, 1'b1); chk("f1_hold_instr", instr, 32'h00500093);
            chkb("f1_hold_upd", update_pc, 1'b0);
    tick(); chkb("f1_step_upd", update_pc, 1'b1); chk("f1_step_count", fetch_count, 32'd0);
    fetch_en = 1'b0;
    tick(); chkb("f1_idle_upd", update_pc, 1'b0); chk("f1_count", fetch_count, 32'd1);
            chkb("f1_idle_ivalid", instr_valid, 1'b0);
    tick(); chkb("f1_idle_noreq", mem_bus.mem_req_valid, 1'b0);

    // Request stalled 10+ cycles with a spurious response, then decode stalled 3 cycles.
    pc_current = 32'h100; fetch_en = 1'b1; instr_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b0; mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 32'hDEADBEEF;
    tick();
    fetch_en = 1'b0; pc_current = 32'h200;
    for (int i = 0; i < 10; i++) begin
      chkb("st_req_valid", mem_bus.mem_req_valid, 1'b1);
      chk("st_req_addr", mem_bus.mem_req_addr, 32'h100);
      tick();
    end
    chkb("st_req_still", mem_bus.mem_req_valid, 1'b1);
    chk("st_spurious_instr", instr, 32'h00500093);
    mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b0;
    tick(); chkb("st_wait_valid", mem_bus.mem_req_valid, 1'b0);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 32'h12345678;
    tick();
    mem_bus.mem_resp_data = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      chkb("st_hold_ivalid", instr_valid, 1'b1);
      chk("st_hold_instr", instr, 32'h12345678);
      chkb("st_hold_upd", update_pc, 1'b0);
      tick();
    end
    instr_ready = 1'b1;
    tick(); chkb("st_step_upd", update_pc, 1'b1);
    tick(); chkb("st_idle_upd", update_pc, 1'b0); chk("st_count", fetch_count, 32'd2);
    tick(); tick();
    chkb("st_stopped_req", mem_bus.mem_req_valid, 1'b0); chkb("st_stopped_upd", update_pc, 1'b0);
    chk("st_stopped_count", fetch_count, 32'd2);

    // Response on the 4th WAIT cycle beats the timeout.
    pc_current = 32'h80; fetch_en = 1'b1; instr_ready = 1'b0;
    mem_bus.mem_req_ready = 1'b1; mem_bus.mem_resp_valid = 1'b0;
    tick(); fetch_en = 1'b0;
    tick(); tick(); tick(); tick();
    chkb("to4_wait4_fault", fetch_fault, 1'b0); chkb("to4_wait4_ivalid", instr_valid, 1'b0);
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 32'hA5A5A5A5;
    tick(); chkb("to4_hold_ivalid", instr_valid, 1'b1); chk("to4_hold_instr", instr, 32'hA5A5A5A5);
            chkb("to4_hold_fault", fetch_fault, 1'b0);
    mem_bus.mem_resp_valid = 1'b0; instr_ready = 1'b1;
    tick(); tick(); chk("to4_count", fetch_count, 32'd3);

    // No response: timeout fault after 4 WAIT cycles, then terminal.
    pc_current = 32'h84; fetch_en = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chkb("to_w4_fault", fetch_fault, 1'b0);
    tick();
    chkb("to_fault", fetch_fault, 1'b1); chk("to_cause", 32'(fault_cause), 32'h3);
    chk("to_addr", fault_addr, 32'h84); chkb("to_req_valid", mem_bus.mem_req_valid, 1'b0);
    chkb("to_ivalid", instr_valid, 1'b0);
    mem_bus.mem_resp_valid = 1'b1;
    tick(); tick(); tick();
    chkb("to_hold_fault", fetch_fault, 1'b1); chk("to_hold_cause", 32'(fault_cause), 32'h3);
    chkb("to_hold_req", mem_bus.mem_req_valid, 1'b0); chkb("to_hold_upd", update_pc, 1'b0);
    chk("to_hold_instr", instr, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1 chk_zero("rst_fault");
    tick();

    // Reset asserted mid-WAIT clears everything without a clock edge.
    pc_current = 32'h40; fetch_en = 1'b1; mem_bus.mem_resp_valid = 1'b0; rst_n = 1'b1;
    tick(); tick(); chk("rw_addr", mem_bus.mem_req_addr, 32'h40);
    rst_n = 1'b0;
    #1 chk_zero("rst_wait");
    tick();

    // Bus error at 0x40.
    mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_err = 1'b1; mem_bus.mem_resp_data = 32'h55555555;
    rst_n = 1'b1;
    tick(); tick(); tick();
    chkb("be_fault", fetch_fault, 1'b1); chk("be_cause", 32'(fault_cause), 32'h2);
    chk("be_addr", fault_addr, 32'h40); chk("be_instr", instr, 32'h0);
    tick(); tick(); tick();
    chkb("be_hold_fault", fetch_fault, 1'b1); chk("be_hold_cause", 32'(fault_cause), 32'h2);
    chkb("be_hold_req", mem_bus.mem_req_valid, 1'b0);
    rst_n = 1'b0;
    #1 chk_zero("rst_be");
    tick();

    // Misaligned PC faults straight from IDLE without a request.
    pc_current = 32'h102; mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_resp_err = 1'b0; rst_n = 1'b1;
    tick();
    chkb("ma_fault", fetch_fault, 1'b1); chk("ma_cause", 32'(fault_cause), 32'h1);
    chk("ma_addr", fault_addr, 32'h102); chkb("ma_req", mem_bus.mem_req_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chkb("ma_hold_req", mem_bus.mem_req_valid, 1'b0);
      chkb("ma_hold_fault", fetch_fault, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
